systolic_feed_ctrl: RTL and testbench

Sequencer for the bank of transpose FIFOs that feed the skewed edge of the systolic matrix-multiply array. On `start` it bulk-loads all lane FIFOs in one cycle, then issues per-lane shift enables staggered by one cycle per lane, so lane i emits its DEPTH words i cycles after lane 0. It honours the downstream `stall`, waits a programmable drain interval for the array to flush, and then pulses `done`. One instance sits beside the FIFO bank and drives each FIFO's WrEn/en.

---
 rtl/systolic_feed_ctrl_pkg.sv | 26 ++
 rtl/systolic_feed_ctrl_if.sv | 27 ++
 rtl/systolic_feed_ctrl_window_dec.sv | 27 ++
 rtl/systolic_feed_ctrl.sv | 87 ++++++++
 tb/tb_systolic_feed_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the systolic feed path: sequencer states, default
// array geometry and counter-width helpers.
package systolic_pkg;

  localparam int DEFAULT_DIM   = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN,
    DONE
  } feed_state_t;

  // Feed counter must reach DIM+DEPTH-2.
  function automatic int cnt_width(input int dim, input int depth);
    return $clog2(dim + depth);
  endfunction

  // A zero-length drain still needs a legal 1-bit counter.
  function automatic int drain_width(input int drain_cycles);
    return (drain_cycles > 0) ? $clog2(drain_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Control/handshake bundle between the requester and the feed sequencer.
interface systolic_feed_ctrl_if
  import systolic_pkg::*;
#(
  parameter int DIM = DEFAULT_DIM
) ();

  logic           start;
  logic           clr;
  logic           stall;
  logic [DIM-1:0] wr_en;
  logic [DIM-1:0] en;
  logic [DIM-1:0] vld;
  logic           busy;
  logic           done;

  modport master (
    output start, clr, stall,
    input  wr_en, en, vld, busy, done
  );

  modport slave (
    input  start, clr, stall,
    output wr_en, en, vld, busy, done
  );

endinterface

// File: rtl/systolic_feed_ctrl_window_dec.sv
// Skewed lane window: lane i is open while i <= cnt <= i+DEPTH-1.
// Shared with the result collector, which uses the same skew.
module feed_window_dec
  import systolic_pkg::*;
#(
  parameter  int DIM   = DEFAULT_DIM,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = cnt_width(DIM, DEPTH)
) (
  input  logic           active,
  input  logic [CW-1:0]  cnt,
  output logic [DIM-1:0] win
);

  logic [31:0] cnt_ext;

  assign cnt_ext = 32'(cnt);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win = '0;
    for (int i = 0; i < DIM; i++) begin
      win[i] = active && (cnt_ext >= 32'(i)) && (cnt_ext <= 32'(i + DEPTH - 1));
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the transpose FIFO bank: bulk load, staggered per-lane shift,
// stall-aware drain, then a one-cycle done pulse.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int DIM          = DEFAULT_DIM,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int DRAIN_CYCLES = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  systolic_feed_ctrl_if.slave bus
);

  localparam int CW = cnt_width(DIM, DEPTH);
  localparam int DW = drain_width(DRAIN_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIM + DEPTH - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  feed_state_t    state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  drain_cnt;
  logic           feed_last;
  logic           drain_last;
  logic [DIM-1:0] win;

  assign feed_last  = (state == FEED)  && !bus.stall && (cnt == CNT_LAST);
  assign drain_last = (state == DRAIN) && !bus.stall && (drain_cnt == DRAIN_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start) state_nxt = LOAD;
        LOAD:    state_nxt = FEED;
        FEED:    if (feed_last) state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        DRAIN:   if (drain_last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters rest at zero outside their state, so each entry starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      drain_cnt <= '0;
    end else if (bus.clr) begin
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      if (state != FEED || feed_last) cnt <= '0;
      else if (!bus.stall)            cnt <= cnt + 1'b1;

      if (state != DRAIN || drain_last) drain_cnt <= '0;
      else if (!bus.stall)              drain_cnt <= drain_cnt + 1'b1;
    end
  end

  feed_window_dec #(
    .DIM   (DIM),
    .DEPTH (DEPTH)
  ) u_win (
    .active (state == FEED),
    .cnt    (cnt),
    .win    (win)
  );

  // Shift/valid follow the live stall; everything else is a pure state decode.
  always_comb begin
    bus.en    = win & {DIM{!bus.stall}};
    bus.vld   = win & {DIM{!bus.stall}};
    bus.wr_en = (state == LOAD) ? '1 : '0;
    bus.busy  = (state == LOAD) || (state == FEED) || (state == DRAIN);
    bus.done  = (state == DONE);
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench: nominal/stall/abort/reset on an 8x8 instance, corner timing on
// a 1x1 instance, and a 4-lane FIFO bank model checking the skewed transpose.
module tb_systolic_feed_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.DIM(8)) b8 ();
  systolic_feed_ctrl_if #(.DIM(1)) b1 ();
  systolic_feed_ctrl_if #(.DIM(4)) b4 ();

  systolic_feed_ctrl #(.DIM(8), .DEPTH(8), .DRAIN_CYCLES(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  systolic_feed_ctrl #(.DIM(1), .DEPTH(1), .DRAIN_CYCLES(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  systolic_feed_ctrl #(.DIM(4), .DEPTH(4), .DRAIN_CYCLES(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand-computed en/vld pattern for the 8x8 instance, one entry per FEED cycle.
  logic [7:0] en_tbl8 [15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                               8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
  logic [3:0] en_tbl4 [7]  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  // Four-lane transpose FIFO bank: parallel load of word 16*lane+w, shift on en.
  logic [7:0] fmem [4][4];
  int         ptr  [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (b4.wr_en[i]) begin
        for (int w = 0; w < 4; w++) fmem[i][w] <= 8'(16 * i + w);
        ptr[i] <= 0;
      end else if (b4.en[i]) begin
        ptr[i] <= ptr[i] + 1;
      end
    end
  end

  function automatic logic [7:0] fifo_head(input int i);
    return (ptr[i] < 4) ? fmem[i][ptr[i][1:0]] : 8'hEE;
  endfunction

  function automatic logic [7:0] exp_en8(input int k, input int st_from, input int st_len);
    int idx;
    if (st_len > 0 && k >= st_from && k < st_from + st_len) return 8'h00;
    idx = k - 2 - ((st_len > 0 && k >= st_from + st_len) ? st_len : 0);
    if (idx < 0 || idx > 14) return 8'h00;
    return en_tbl8[idx];
  endfunction

  task automatic all_zero8(input string tag);
    check(tag, 32'({b8.wr_en, b8.en, b8.vld, b8.busy, b8.done}), 32'h0);
  endtask

  // One 8x8 operation; cycle k is the k-th cycle after the edge that took start.
  task automatic run8(input string tag, input int st_from, input int st_len, input int done_at);
    logic [7:0] e;
    @(negedge clk);
    b8.start = 1'b1;
    @(posedge clk);
    #1 b8.start = 1'b0;
    for (int k = 1; k <= done_at + 2; k++) begin
      b8.stall = (st_len > 0) && (k >= st_from) && (k < st_from + st_len);
      @(negedge clk);
      e = exp_en8(k, st_from, st_len);
      check($sformatf("%s_wr_en_%0d", tag, k), 32'(b8.wr_en), (k == 1) ? 32'hFF : 32'h0);
      check($sformatf("%s_en_%0d", tag, k), 32'(b8.en), 32'(e));
      check($sformatf("%s_vld_%0d", tag, k), 32'(b8.vld), 32'(e));
      check($sformatf("%s_busy_%0d", tag, k), 32'(b8.busy), 32'(k < done_at));
      check($sformatf("%s_done_%0d", tag, k), 32'(b8.done), 32'(k == done_at));
      @(posedge clk);
      #1;
    end
    b8.stall = 1'b0;
  endtask

  initial begin
    logic [3:0] ev;
    b8.start = 1'b0; b8.clr = 1'b0; b8.stall = 1'b0;
    b1.start = 1'b0; b1.clr = 1'b0; b1.stall = 1'b0;
    b4.start = 1'b0; b4.clr = 1'b0; b4.stall = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    all_zero8("in_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      all_zero8($sformatf("idle_%0d", k));
      check($sformatf("idle4_%0d", k), 32'({b4.wr_en, b4.en, b4.busy, b4.done}), 32'h0);
    end

    // Nominal and stalled 8x8 runs
    run8("nom", 0, 0, 25);
    repeat (3) @(posedge clk);
    #1;
    run8("stall", 7, 3, 28);

    // Abort at cnt=4 (cycle T+6)
    @(negedge clk);
    b8.start = 1'b1;
    @(posedge clk);
    #1 b8.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 b8.clr = 1'b1;
    @(negedge clk);
    check("abort_en", 32'(b8.en), 32'h1F);
    @(posedge clk);
    #1 b8.clr = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      all_zero8($sformatf("abort_idle_%0d", k));
    end
    @(posedge clk);
    #1;
    run8("rerun", 0, 0, 25);

    // Asynchronous reset in DRAIN (cycle T+20)
    @(negedge clk);
    b8.start = 1'b1;
    @(posedge clk);
    #1 b8.start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(b8.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1 all_zero8("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1x1, no drain
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("e1_wr_en_%0d", k), 32'(b1.wr_en), 32'(k == 1));
      check($sformatf("e1_en_%0d", k), 32'(b1.en), 32'(k == 2));
      check($sformatf("e1_vld_%0d", k), 32'(b1.vld), 32'(k == 2));
      check($sformatf("e1_busy_%0d", k), 32'(b1.busy), 32'(k <= 2));
      check($sformatf("e1_done_%0d", k), 32'(b1.done), 32'(k == 3));
      @(posedge clk);
      #1;
    end

    // Back-to-back with start held high: done -> next wr_en gap is 2
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("b2b_wr_en_%0d", k), 32'(b1.wr_en), 32'(k % 4 == 1));
      check($sformatf("b2b_done_%0d", k), 32'(b1.done), 32'(k % 4 == 3));
      @(posedge clk);
      #1;
    end
    b1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 4x4 with FIFO bank model; start pulse during busy must be ignored
    @(negedge clk);
    b4.start = 1'b1;
    @(posedge clk);
    #1 b4.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      b4.start = (k == 4);
      @(negedge clk);
      ev = (k >= 2 && k <= 8) ? en_tbl4[k - 2] : 4'h0;
      check($sformatf("f4_wr_en_%0d", k), 32'(b4.wr_en), (k == 1) ? 32'hF : 32'h0);
      check($sformatf("f4_vld_%0d", k), 32'(b4.vld), 32'(ev));
      check($sformatf("f4_busy_%0d", k), 32'(b4.busy), 32'(k <= 10));
      check($sformatf("f4_done_%0d", k), 32'(b4.done), 32'(k == 11));
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) check($sformatf("f4_word_l%0d_%0d", i, k), 32'(fifo_head(i)), 32'(16 * i + (k - 2 - i)));
      end
      @(posedge clk);
      #1;
    end
    b4.start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
